// File: rtl/clock_mode_ctrl.sv
// Mode controller for the digital clock: prescaler, button edge detect, mode FSM, blink and display mux.
// Latency: button press to control outputs 1 cycle; digit inputs and mode to disp_digits 1 cycle.
// Backpressure: none; buttons are sampled every cycle and every output is a level or a one-cycle pulse.
module clock_mode_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic [15:0] tk_digits,
  input  logic [15:0] sw_digits,
  input  logic [15:0] al_digits,
  output logic        enb,
  output logic [1:0]  mode,
  output logic        sw_sel,
  output logic        sw_run,
  output logic        sw_clr,
  output logic        inc_tk,
  output logic        inc_al,
  output logic        inc_field,
  output logic [15:0] disp_digits,
  output logic [3:0]  disp_blank
);

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    STOPWATCH = 2'd1,
    SET_TIME  = 2'd2,
    SET_ALARM = 2'd3
  } mode_t;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  logic  mode_prev;
  logic  a_prev;
  logic  b_prev;
  logic  press_mode;
  logic  press_a;
  logic  press_b;

  mode_t state;
  mode_t state_next;
  logic  field;
  logic  blink_phase;

  // Free-running prescaler; enb is decoded from the terminal count so it lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  assign enb = (tick_cnt == TICK_LAST);

  // Button history; reset to 1 so a button held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_prev <= 1'b1;
      a_prev    <= 1'b1;
      b_prev    <= 1'b1;
    end else begin
      mode_prev <= btn_mode;
      a_prev    <= btn_a;
      b_prev    <= btn_b;
    end
  end

  // A mode change takes priority, so a/b presses on the same edge are dropped here.
  assign press_mode = btn_mode & ~mode_prev;
  assign press_a    = btn_a & ~a_prev & ~press_mode;
  assign press_b    = btn_b & ~b_prev & ~press_mode;

  assign state_next = mode_t'(state + 2'd1);

  // Mode FSM with registered stopwatch controls, increment pulses, field select and blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLOCK;
      sw_sel      <= 1'b0;
      sw_run      <= 1'b0;
      sw_clr      <= 1'b0;
      inc_tk      <= 1'b0;
      inc_al      <= 1'b0;
      field       <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      sw_clr <= 1'b0;
      inc_tk <= 1'b0;
      inc_al <= 1'b0;
      if (press_mode) begin
        state       <= state_next;
        sw_sel      <= (state_next == STOPWATCH);
        // Leaving the stopwatch pauses it; the count itself lives elsewhere and is kept.
        sw_run      <= 1'b0;
        // Set modes always start editing the high pair, display solid.
        field       <= (state_next == SET_TIME) || (state_next == SET_ALARM);
        blink_phase <= 1'b0;
      end else begin
        case (state)
          STOPWATCH: begin
            if (press_a) begin
              sw_run <= ~sw_run;
            end
            // Clearing a running stopwatch is refused; the current run state decides.
            if (press_b && !sw_run) begin
              sw_clr <= 1'b1;
            end
          end
          SET_TIME, SET_ALARM: begin
            if (press_b) begin
              field <= ~field;
            end
            // An increment shows the field solid immediately, even on a tick cycle.
            if (press_a) begin
              inc_tk      <= (state == SET_TIME);
              inc_al      <= (state == SET_ALARM);
              blink_phase <= 1'b0;
            end else if (enb) begin
              blink_phase <= ~blink_phase;
            end
          end
          default: begin
            field       <= 1'b0;
            blink_phase <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mode      = state;
  assign inc_field = field;

  // Blank the pair being edited during the off half of the blink.
  always_comb begin
    disp_blank = 4'b0000;
    if (blink_phase) begin
      disp_blank = field ? 4'b1100 : 4'b0011;
    end
  end

  // Registered display mux; set-time edits the live timekeeping digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_digits <= 16'h0000;
    end else begin
      case (state)
        STOPWATCH: disp_digits <= sw_digits;
        SET_ALARM: disp_digits <= al_digits;
        default:   disp_digits <= tk_digits;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl with TICK_DIV=4: stimulus queues expected outputs per cycle.
// Latency: expectations are tagged with the clock edge count they refer to.
// Backpressure: none; the monitor compares every queued entry at the falling edge of its cycle.
module tb_clock_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_a = 1'b0;
  logic        btn_b = 1'b0;
  logic [15:0] tk_digits = 16'h0959;
  logic [15:0] sw_digits = 16'h0042;
  logic [15:0] al_digits = 16'h0630;
  logic        enb;
  logic [1:0]  mode;
  logic        sw_sel;
  logic        sw_run;
  logic        sw_clr;
  logic        inc_tk;
  logic        inc_al;
  logic        inc_field;
  logic [15:0] disp_digits;
  logic [3:0]  disp_blank;

  clock_mode_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_a(btn_a), .btn_b(btn_b),
    .tk_digits(tk_digits), .sw_digits(sw_digits), .al_digits(al_digits),
    .enb(enb), .mode(mode), .sw_sel(sw_sel), .sw_run(sw_run), .sw_clr(sw_clr),
    .inc_tk(inc_tk), .inc_al(inc_al), .inc_field(inc_field),
    .disp_digits(disp_digits), .disp_blank(disp_blank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output vector layout: enb, mode, sw_sel, sw_run, sw_clr, inc_tk, inc_al, inc_field, digits, blank
  localparam logic [28:0] M_ENB   = 29'h1 << 28;
  localparam logic [28:0] M_MODE  = 29'h3 << 26;
  localparam logic [28:0] M_SEL   = 29'h1 << 25;
  localparam logic [28:0] M_RUN   = 29'h1 << 24;
  localparam logic [28:0] M_CLR   = 29'h1 << 23;
  localparam logic [28:0] M_TK    = 29'h1 << 22;
  localparam logic [28:0] M_AL    = 29'h1 << 21;
  localparam logic [28:0] M_FLD   = 29'h1 << 20;
  localparam logic [28:0] M_DISP  = 29'hFFFF << 4;
  localparam logic [28:0] M_BLANK = 29'hF;

  typedef struct {
    int          cyc;
    string       nm;
    logic [28:0] v;
    logic [28:0] m;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   k0 = 0;
  int   last_mode_edge = 0;
  logic [28:0] obs;

  assign obs = {enb, mode, sw_sel, sw_run, sw_clr, inc_tk, inc_al, inc_field, disp_digits, disp_blank};

  // Monitor: pop every expectation due this cycle and compare the masked outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: missed cycle %0d (now %0d)", e.nm, e.cyc, cyc);
      end else if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s @cyc %0d: got %h want %h (mask %h)", e.nm, cyc, obs & e.m, e.v & e.m, e.m);
      end
    end
  end

  function automatic void push(string nm, logic [28:0] v, logic [28:0] m);
    exp_t x;
    x.cyc = cyc;
    x.nm  = nm;
    x.v   = v;
    x.m   = m;
    sb.push_back(x);
  endfunction

  function automatic void exp_zero(string nm);
    push(nm, 29'h0, {29{1'b1}});
  endfunction

  function automatic void exp_mode(string nm, logic [1:0] m);
    push(nm, (29'(m) << 26) | (29'(m == 2'd1) << 25), M_MODE | M_SEL);
  endfunction

  function automatic void exp_sw(string nm, logic run, logic clr);
    push(nm, (29'(run) << 24) | (29'(clr) << 23), M_RUN | M_CLR);
  endfunction

  function automatic void exp_inc(string nm, logic tk, logic al, logic fld);
    push(nm, (29'(tk) << 22) | (29'(al) << 21) | (29'(fld) << 20), M_TK | M_AL | M_FLD);
  endfunction

  function automatic void exp_disp(string nm, logic [15:0] d);
    push(nm, 29'(d) << 4, M_DISP);
  endfunction

  function automatic void exp_blank(string nm, logic [3:0] b);
    push(nm, 29'(b), M_BLANK);
  endfunction

  function automatic void exp_enb(string nm, logic x);
    push(nm, 29'(x) << 28, M_ENB);
  endfunction

  // Edge at which blink toggles: the edge closing a cycle whose prescaler count is 3.
  function automatic int first_tick_after(int t);
    int c = t + 1;
    while (((c - k0) % 4) != 0) c++;
    return c;
  endfunction

  function automatic logic [15:0] digits_for(logic [1:0] m);
    case (m)
      2'd1:    return sw_digits;
      2'd3:    return al_digits;
      default: return tk_digits;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int t);
    while (cyc < t) tick();
  endtask

  // Mode button held three cycles: one step on the press edge, no further change.
  task automatic mode_hold3(logic [1:0] m);
    btn_mode = 1'b1;
    tick();
    last_mode_edge = cyc;
    exp_mode("mode_step", m);
    tick();
    exp_mode("mode_hold1", m);
    exp_disp("disp_mux", digits_for(m));
    tick();
    exp_mode("mode_hold2", m);
    btn_mode = 1'b0;
    tick();
    exp_mode("mode_release", m);
  endtask

  initial begin
    int c;
    // 1. reset and prescaler
    tick();
    exp_zero("reset_state1");
    tick();
    exp_zero("reset_state2");
    rst = 1'b0;
    k0 = cyc;
    for (int j = 0; j < 9; j++) begin
      exp_enb("enb_phase", (j % 4) == 3);
      if (j == 1) exp_disp("disp_clock", 16'h0959);
      if (j == 1) exp_mode("mode_after_reset", 2'd0);
      tick();
    end

    // 2. mode cycling
    mode_hold3(2'd1);
    mode_hold3(2'd2);
    mode_hold3(2'd3);
    mode_hold3(2'd0);

    // 3. stopwatch controls
    mode_hold3(2'd1);
    btn_a = 1'b1; tick(); exp_sw("sw_start", 1'b1, 1'b0);
    btn_a = 1'b0; tick(); exp_sw("sw_run_hold", 1'b1, 1'b0);
    btn_b = 1'b1; tick(); exp_sw("sw_clr_blocked", 1'b1, 1'b0);
    btn_b = 1'b0; tick(); exp_sw("sw_clr_blocked2", 1'b1, 1'b0);
    btn_a = 1'b1; tick(); exp_sw("sw_stop", 1'b0, 1'b0);
    btn_a = 1'b0; tick();
    btn_b = 1'b1; tick(); exp_sw("sw_clr_pulse", 1'b0, 1'b1);
    tick(); exp_sw("sw_clr_one_cycle", 1'b0, 1'b0);
    btn_b = 1'b0; tick(); exp_sw("sw_clr_idle", 1'b0, 1'b0);
    btn_a = 1'b1; tick(); exp_sw("sw_restart", 1'b1, 1'b0);
    btn_a = 1'b0; tick();

    // 4. leave stopwatch into SET_TIME
    tk_digits = 16'h1234;
    btn_mode = 1'b1; tick();
    last_mode_edge = cyc;
    exp_mode("to_set_time", 2'd2);
    exp_sw("sw_forced_stop", 1'b0, 1'b0);
    exp_inc("set_entry_field", 1'b0, 1'b0, 1'b1);
    btn_mode = 1'b0; tick();
    exp_disp("disp_set_time", 16'h1234);
    exp_inc("field_high", 1'b0, 1'b0, 1'b1);
    c = first_tick_after(last_mode_edge);
    run_to(c - 1); exp_blank("blank_before_tick", 4'b0000);
    run_to(c);     exp_blank("blank_tick1", 4'b1100);
    run_to(c + 4); exp_blank("blank_tick2", 4'b0000);
    btn_a = 1'b1; tick(); exp_inc("inc_tk_pulse", 1'b1, 1'b0, 1'b1);
    btn_a = 1'b0; tick(); exp_inc("inc_tk_end", 1'b0, 1'b0, 1'b1);
    run_to(c + 8); exp_blank("blank_tick3", 4'b1100);
    btn_a = 1'b1; tick();
    exp_blank("press_clears_blink", 4'b0000);
    exp_inc("inc_tk_pulse2", 1'b1, 1'b0, 1'b1);
    btn_a = 1'b0; btn_b = 1'b1; tick();
    exp_inc("field_low", 1'b0, 1'b0, 1'b0);
    btn_b = 1'b0;
    run_to(c + 11); exp_blank("blank_low_off", 4'b0000);
    run_to(c + 12); exp_blank("blank_low", 4'b0011);
    run_to(c + 15); btn_a = 1'b1;
    tick();
    exp_blank("press_beats_enb", 4'b0000);
    exp_inc("inc_on_tick", 1'b1, 1'b0, 1'b0);
    btn_a = 1'b0;
    run_to(c + 20); exp_blank("blank_low2", 4'b0011);

    // 5. SET_ALARM, then the same-edge mode+a case
    mode_hold3(2'd3);
    exp_inc("alarm_field_high", 1'b0, 1'b0, 1'b1);
    exp_disp("disp_alarm", 16'h0630);
    btn_a = 1'b1; tick(); exp_inc("inc_al_pulse", 1'b0, 1'b1, 1'b1);
    btn_a = 1'b0; tick(); exp_inc("inc_al_end", 1'b0, 1'b0, 1'b1);
    mode_hold3(2'd0);
    exp_inc("clock_field_zero", 1'b0, 1'b0, 1'b0);
    exp_blank("clock_blank_zero", 4'b0000);
    mode_hold3(2'd1);
    exp_sw("sw_still_stopped", 1'b0, 1'b0);
    btn_a = 1'b1; tick(); exp_sw("sw_start2", 1'b1, 1'b0);
    btn_a = 1'b0; tick();
    btn_mode = 1'b1; btn_a = 1'b1; tick();
    exp_mode("mode_a_same_edge", 2'd2);
    exp_sw("sw_stop_same_edge", 1'b0, 1'b0);
    exp_inc("no_inc_same_edge", 1'b0, 1'b0, 1'b1);
    btn_mode = 1'b0; btn_a = 1'b0; tick();
    exp_inc("no_inc_after", 1'b0, 1'b0, 1'b1);
    mode_hold3(2'd3);

    // 6. reset while blanking in SET_ALARM with btn_a held
    c = first_tick_after(last_mode_edge);
    while (c < cyc) c += 8;
    run_to(c); exp_blank("alarm_blanking", 4'b1100);
    rst = 1'b1; btn_a = 1'b1; tick();
    exp_zero("reset_mid_op");
    tick();
    exp_zero("reset_mid_op2");
    rst = 1'b0;
    k0 = cyc;
    for (int j = 0; j < 8; j++) begin
      exp_inc("no_inc_after_reset", 1'b0, 1'b0, 1'b0);
      exp_mode("mode_after_reset2", 2'd0);
      exp_enb("enb_restart", (j % 4) == 3);
      tick();
    end
    btn_a = 1'b0;
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
